// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin front end for one shared combinational Booth multiplier.
// Optional MUL_SHARE_PERF_EN adds saturating per-requester grant counters.

module multiplier #(
  parameter int unsigned N = 11
) (
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] result
);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] b_ext;
  logic           prev;

  // Radix-2 Booth recoding of A; both operands are two's complement.
  always_comb begin
    acc   = '0;
    b_ext = {{N{B[N-1]}}, B};
    prev  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      case ({A[i], prev})
        2'b01:   acc = acc + (b_ext << i);
        2'b10:   acc = acc - (b_ext << i);
        default: acc = acc;
      endcase
      prev = A[i];
    end
    result = acc;
  end

endmodule

module mul_share_ctrl #(
  parameter int unsigned N     = 11,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [N-1:0]     req0_a_i,
  input  logic [N-1:0]     req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [N-1:0]     req1_a_i,
  input  logic [N-1:0]     req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [2*N-1:0]   rsp_result_o
`ifdef MUL_SHARE_PERF_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           id_q, id_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic [2*N-1:0] result_q, result_d;
  logic [2*N-1:0] mul_result;
  logic           grant0, grant1;

  multiplier #(.N(N)) u_mul (
    .A      (op_a_q),
    .B      (op_b_q),
    .result (mul_result)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    // On a tie the requester that did not win last time is served.
    grant0 = (state_q == IDLE) && req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1 = (state_q == IDLE) && req1_valid_i && (!req0_valid_i || !last_grant_q);
    case (state_q)
      IDLE: begin
        if (grant0) begin
          req0_ready_o = 1'b1;
          op_a_d       = req0_a_i;
          op_b_d       = req0_b_i;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = CALC;
        end else if (grant1) begin
          req1_ready_o = 1'b1;
          op_a_d       = req1_a_i;
          op_b_d       = req1_b_i;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = CALC;
        end
      end
      CALC: begin
        result_d = mul_result;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;

`ifdef MUL_SHARE_PERF_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: arbitration, latency, backpressure, async reset, Booth results.
// Grant counters are checked when MUL_SHARE_PERF_EN is defined (built with CNT_W=2).

module tb_mul_share_ctrl;

  localparam int unsigned N = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [N-1:0]  req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [2*N-1:0] rsp_result_o;

  int checks = 0;
  int errors = 0;

`ifdef MUL_SHARE_PERF_EN
  logic [1:0] grant_cnt0_o, grant_cnt1_o;

  mul_share_ctrl #(.N(N), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .grant_cnt0_o (grant_cnt0_o),
    .grant_cnt1_o (grant_cnt1_o)
  );
`else
  mul_share_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with the consumer always ready; starts and ends in IDLE.
  task automatic run_op(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp);
    if (sel) begin req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; end
    else     begin req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; end
    #1;
    chk("op_ready", sel ? req1_ready_o : req0_ready_o, 1'b1);
    chk("op_other_ready", sel ? req0_ready_o : req1_ready_o, 1'b0);
    tick();
    if (sel) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    #1;
    chk("op_calc_valid", rsp_valid_o, 1'b0);
    tick();
    chk("op_rsp_valid", rsp_valid_o, 1'b1);
    chk("op_result", rsp_result_o, exp);
    chk("op_id", rsp_id_o, sel);
    tick();
    chk("op_done_valid", rsp_valid_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_a_i = '0; req0_b_i = '0; req1_a_i = '0; req1_b_i = '0;
    rsp_ready_i = 1'b0;
    #1;
    chk("rst_valid", rsp_valid_o, 1'b0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_id", rsp_id_o, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ready0", req0_ready_o, 1'b0);
      chk("idle_ready1", req1_ready_o, 1'b0);
      chk("idle_valid", rsp_valid_o, 1'b0);
      chk("idle_result", rsp_result_o, 0);
      chk("idle_id", rsp_id_o, 1'b0);
    end

    // req0 only, 4 x 12, consumer not ready until response seen
    req0_valid_i = 1'b1; req0_a_i = 11'd4; req0_b_i = 11'd12;
    #1;
    chk("t2_ready0", req0_ready_o, 1'b1);
    chk("t2_ready1", req1_ready_o, 1'b0);
    tick();
    req0_valid_i = 1'b0;
    #1;
    chk("t2_calc_valid", rsp_valid_o, 1'b0);
    chk("t2_calc_ready0", req0_ready_o, 1'b0);
    tick();
    chk("t2_valid", rsp_valid_o, 1'b1);
    chk("t2_result", rsp_result_o, 48);
    chk("t2_id", rsp_id_o, 1'b0);
    rsp_ready_i = 1'b1;
    tick();
    chk("t2_done", rsp_valid_o, 1'b0);

    // Tie from reset: r0 first, r1 next, then r0 again
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req0_valid_i = 1'b1; req0_a_i = 11'd41; req0_b_i = 11'd18;
    req1_valid_i = 1'b1; req1_a_i = 11'd3;  req1_b_i = 11'd205;
    #1;
    chk("t3_tie_ready0", req0_ready_o, 1'b1);
    chk("t3_tie_ready1", req1_ready_o, 1'b0);
    tick();
    req0_valid_i = 1'b0;
    #1;
    chk("t3_calc_ready1", req1_ready_o, 1'b0);
    tick();
    chk("t3_r0_valid", rsp_valid_o, 1'b1);
    chk("t3_r0_result", rsp_result_o, 738);
    chk("t3_r0_id", rsp_id_o, 1'b0);
    chk("t3_resp_ready1", req1_ready_o, 1'b0);
    tick();
    chk("t3_r1_ready", req1_ready_o, 1'b1);
    tick();
    req1_valid_i = 1'b0;
    tick();
    chk("t3_r1_valid", rsp_valid_o, 1'b1);
    chk("t3_r1_result", rsp_result_o, 615);
    chk("t3_r1_id", rsp_id_o, 1'b1);
    tick();
    run_op(1'b0, 11'd7, 11'd9, 22'd63);
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    chk("t3_alt_ready1", req1_ready_o, 1'b1);
    chk("t3_alt_ready0", req0_ready_o, 1'b0);
    tick();
    req1_valid_i = 1'b0;
    #1;
    chk("t3_alt_calc_ready0", req0_ready_o, 1'b0);
    tick();
    chk("t3_alt_result", rsp_result_o, 615);
    tick();
    chk("t3_alt_r0_ready", req0_ready_o, 1'b1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    chk("t3_alt_r0_result", rsp_result_o, 63);
    tick();

    // Backpressure: req1 5 x 7 held in RESP while req0 waits
    rsp_ready_i = 1'b0;
    req1_valid_i = 1'b1; req1_a_i = 11'd5; req1_b_i = 11'd7;
    #1;
    chk("t4_ready1", req1_ready_o, 1'b1);
    tick();
    req1_valid_i = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 11'd2; req0_b_i = 11'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid_o, 1'b1);
      chk("t4_hold_result", rsp_result_o, 35);
      chk("t4_hold_id", rsp_id_o, 1'b1);
      chk("t4_hold_ready0", req0_ready_o, 1'b0);
      chk("t4_hold_ready1", req1_ready_o, 1'b0);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("t4_release_valid", rsp_valid_o, 1'b0);
    chk("t4_release_ready0", req0_ready_o, 1'b1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    chk("t4_next_result", rsp_result_o, 6);
    chk("t4_next_id", rsp_id_o, 1'b0);
    tick();

    // Signed boundaries: -3 x 5 and -1024 x -1024
    run_op(1'b1, 11'h7FD, 11'd5, 22'h3FFFF1);
    run_op(1'b0, 11'h400, 11'h400, 22'd1048576);

    // Reset during CALC drops the product
    req0_valid_i = 1'b1; req0_a_i = 11'd100; req0_b_i = 11'd100;
    tick();
    req0_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", rsp_valid_o, 1'b0);
    chk("t5_rst_result", rsp_result_o, 0);
    chk("t5_rst_ready0", req0_ready_o, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", rsp_valid_o, 1'b0);
    end
    run_op(1'b0, 11'd13, 11'd12, 22'd156);

`ifdef MUL_SHARE_PERF_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("t6_rst_cnt1", grant_cnt1_o, 0);
    for (int i = 0; i < 5; i++) run_op(1'b1, 11'd2, 11'd2, 22'd4);
    chk("t6_cnt1_sat", grant_cnt1_o, 3);
    chk("t6_cnt0", grant_cnt0_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
